// File: rtl/inc_share_pkg.sv
// Shared constants, FSM state type and helpers for the shared-incrementer counter bank.
package inc_share_pkg;

    localparam int unsigned N_CH_DEF  = 3;
    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

    // Sized for the largest supported bank; callers keep the low N_CH bits.
    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'(1) << idx;
    endfunction

endpackage

// File: rtl/inc_share_arbiter_if.sv
// Request/control and count/status bundle between the counter bank and its user.
import inc_share_pkg::*;

interface inc_share_arbiter_if #(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic                  i_en;
    logic [N_CH-1:0]       i_req;
    logic [N_CH-1:0]       i_clr;
    logic [WIDTH-1:0]      i_tc_val;
    logic                  i_stop_at_tc;
    logic [N_CH*WIDTH-1:0] o_count;
    logic [N_CH-1:0]       o_gnt;
    logic [N_CH-1:0]       o_done;
    logic                  o_busy;

    modport slave (
        input  i_en, i_req, i_clr, i_tc_val, i_stop_at_tc,
        output o_count, o_gnt, o_done, o_busy
    );

    modport master (
        output i_en, i_req, i_clr, i_tc_val, i_stop_at_tc,
        input  o_count, o_gnt, o_done, o_busy
    );
endinterface

// File: rtl/inc_share_adder.sv
// WIDTH-bit +1 incrementer; the single arithmetic unit shared by every channel.
module inc_share_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum,
    output logic             co
);
    assign {co, sum} = {1'b0, a} + (WIDTH + 1)'(1);
endmodule

// File: rtl/inc_share_arbiter.sv
// Bank of N_CH counters time-sharing one incrementer under round-robin arbitration.
module inc_share_arbiter
    import inc_share_pkg::*;
#(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    inc_share_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count [N_CH];
    logic [PTR_W-1:0] r_ptr;
    logic [N_CH-1:0]  r_gnt, r_done;
    logic             r_busy;

    logic [N_CH-1:0]  w_elig;
    logic             w_any, w_grant, w_unused_co;
    logic [PTR_W-1:0] w_sel, w_idx;
    logic [WIDTH-1:0] w_cur, w_sum, w_next;
    logic [7:0]       w_sel_oh;

    // A channel parked at tc in stop mode must not consume the incrementer.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_elig[i] = bus.i_req[i] & ~bus.i_clr[i]
                        & ~(bus.i_stop_at_tc & (r_count[i] == bus.i_tc_val));
        end
    end

    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % int'(N_CH));
            if (!w_any && w_elig[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    assign w_grant  = w_any && bus.i_en && (r_state != HOLD);
    assign w_cur    = r_count[w_sel];
    assign w_next   = (w_cur == bus.i_tc_val) ? '0 : w_sum;
    assign w_sel_oh = onehot(3'(w_sel));

    inc_share_adder #(.WIDTH(WIDTH)) u_adder (
        .a   (w_cur),
        .sum (w_sum),
        .co  (w_unused_co)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.i_en && w_any) w_state_nxt = RUN;
            RUN: begin
                if (!bus.i_en)  w_state_nxt = HOLD;
                else if (!w_any) w_state_nxt = IDLE;
            end
            HOLD:    if (bus.i_en) w_state_nxt = w_any ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            for (int i = 0; i < N_CH; i++) r_count[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_grant ? w_sel_oh[N_CH-1:0] : '0;
            r_busy  <= w_grant;
            r_done  <= '0;
            if (w_grant) begin
                r_ptr         <= (w_sel == PTR_W'(N_CH - 1)) ? '0 : w_sel + PTR_W'(1);
                r_done[w_sel] <= (w_next == bus.i_tc_val);
            end
            for (int i = 0; i < N_CH; i++) begin
                if (bus.i_clr[i])                            r_count[i] <= '0;
                else if (w_grant && (w_sel == PTR_W'(i)))    r_count[i] <= w_next;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_count_out
        assign bus.o_count[g*WIDTH +: WIDTH] = r_count[g];
    end

    assign bus.o_gnt  = r_gnt;
    assign bus.o_done = r_done;
    assign bus.o_busy = r_busy;
endmodule

// File: tb/tb_inc_share_arbiter.sv
// Directed self-checking bench for inc_share_arbiter (N_CH=3, WIDTH=8).
module tb_inc_share_arbiter;
    localparam int unsigned NC = 3;
    localparam int unsigned W  = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    inc_share_arbiter_if #(.N_CH(NC), .WIDTH(W)) bus ();

    inc_share_arbiter #(.N_CH(NC), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt(input int c2, input int c1, input int c0);
        return {8'h00, 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic clear_all();
        bus.i_req = '0;
        bus.i_clr = 3'b111;
        step();
        bus.i_clr = '0;
    endtask

    initial begin
        int c1_seq [6];
        int d_seq  [6];
        c1_seq = '{1, 2, 3, 4, 0, 1};
        d_seq  = '{0, 0, 0, 2, 0, 0};

        rst_n            = 1'b0;
        bus.i_en         = 1'b0;
        bus.i_req        = '0;
        bus.i_clr        = '0;
        bus.i_tc_val     = 8'd255;
        bus.i_stop_at_tc = 1'b0;
        step();
        step();
        check_eq("rst_count", 32'(bus.o_count), 32'h0);
        check_eq("rst_gnt",   32'(bus.o_gnt),   32'h0);
        check_eq("rst_done",  32'(bus.o_done),  32'h0);
        check_eq("rst_busy",  32'(bus.o_busy),  32'h0);
        rst_n = 1'b1;

        // Full-rate round robin over all three channels.
        bus.i_en  = 1'b1;
        bus.i_req = 3'b111;
        for (int c = 0; c < 9; c++) begin
            step();
            check_eq($sformatf("rr_gnt%0d", c), 32'(bus.o_gnt), 32'(1 << (c % 3)));
            check_eq($sformatf("rr_busy%0d", c), 32'(bus.o_busy), 32'h1);
        end
        check_eq("rr_counts", 32'(bus.o_count), cnt(3, 3, 3));

        // Single channel wrapping at tc=4.
        clear_all();
        bus.i_tc_val = 8'd4;
        bus.i_req    = 3'b010;
        for (int c = 0; c < 6; c++) begin
            step();
            check_eq($sformatf("wrap_cnt%0d", c), 32'(bus.o_count), cnt(0, c1_seq[c], 0));
            check_eq($sformatf("wrap_done%0d", c), 32'(bus.o_done), 32'(d_seq[c]));
        end

        // Stop at tc=2: channel parks and the grant stream dries up.
        clear_all();
        bus.i_tc_val     = 8'd2;
        bus.i_stop_at_tc = 1'b1;
        bus.i_req        = 3'b001;
        step();
        check_eq("stop_cnt1",  32'(bus.o_count), cnt(0, 0, 1));
        check_eq("stop_done1", 32'(bus.o_done),  32'h0);
        step();
        check_eq("stop_cnt2",  32'(bus.o_count), cnt(0, 0, 2));
        check_eq("stop_done2", 32'(bus.o_done),  32'h1);
        for (int c = 0; c < 2; c++) begin
            step();
            check_eq($sformatf("stop_gnt%0d", c),  32'(bus.o_gnt),   32'h0);
            check_eq($sformatf("stop_busy%0d", c), 32'(bus.o_busy),  32'h0);
            check_eq($sformatf("stop_done%0d", c), 32'(bus.o_done),  32'h0);
            check_eq($sformatf("stop_cnt%0d", c),  32'(bus.o_count), cnt(0, 0, 2));
        end

        // Clear overrides a mid-count channel; grant falls to channel 0 then rotates.
        clear_all();
        bus.i_stop_at_tc = 1'b0;
        bus.i_tc_val     = 8'd255;
        bus.i_req        = 3'b010;
        for (int c = 0; c < 5; c++) step();
        check_eq("clr_pre", 32'(bus.o_count), cnt(0, 5, 0));
        bus.i_req = 3'b011;
        bus.i_clr = 3'b010;
        step();
        check_eq("clr_cnt", 32'(bus.o_count), cnt(0, 0, 1));
        check_eq("clr_gnt", 32'(bus.o_gnt),   32'h1);
        bus.i_clr = '0;
        step();
        check_eq("clr_next_gnt", 32'(bus.o_gnt),   32'h2);
        check_eq("clr_next_cnt", 32'(bus.o_count), cnt(0, 1, 1));

        // Hold: counts frozen while en=0; resumes from saved pointer (channel 2).
        bus.i_en  = 1'b0;
        bus.i_req = 3'b111;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq($sformatf("hold_gnt%0d", c), 32'(bus.o_gnt),   32'h0);
            check_eq($sformatf("hold_cnt%0d", c), 32'(bus.o_count), cnt(0, 1, 1));
        end
        bus.i_en = 1'b1;
        step();
        check_eq("resume_hold_gnt", 32'(bus.o_gnt), 32'h0);
        step();
        check_eq("resume_gnt", 32'(bus.o_gnt),   32'h4);
        check_eq("resume_cnt", 32'(bus.o_count), cnt(1, 1, 1));
        step();
        check_eq("resume_gnt2", 32'(bus.o_gnt), 32'h1);

        // Asynchronous reset between edges.
        clear_all();
        bus.i_req = 3'b100;
        for (int c = 0; c < 7; c++) step();
        check_eq("arst_pre", 32'(bus.o_count), cnt(7, 0, 0));
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_count", 32'(bus.o_count), 32'h0);
        check_eq("arst_gnt",   32'(bus.o_gnt),   32'h0);
        check_eq("arst_busy",  32'(bus.o_busy),  32'h0);
        check_eq("arst_done",  32'(bus.o_done),  32'h0);
        step();
        rst_n     = 1'b1;
        bus.i_req = 3'b111;
        step();
        check_eq("arst_first_gnt", 32'(bus.o_gnt),   32'h1);
        check_eq("arst_first_cnt", 32'(bus.o_count), cnt(0, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/inc_share_arbiter.md
Name: inc_share_arbiter

Overview:
- Bank of N_CH up-counters that time-share one WIDTH-bit incrementer.
- A round-robin arbiter picks one requesting channel per cycle.
- The chosen channel's count passes through the shared incrementer and is written back at the same clock edge.
- Sits above the counter datapath and replaces per-counter incrementers; it is the sequencing/sharing controller for the ALU counter group.

Parameters:
- N_CH, 3, number of counter channels (2..8)
- WIDTH, 8, counter width in bits

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state while low
- en  input  1  global run enable; low = HOLD state
- req  input  N_CH  per-channel increment request, level-sensitive
- clr  input  N_CH  per-channel synchronous clear
- tc_val  input  WIDTH  shared terminal count value
- stop_at_tc  input  1  1 = channel stops at tc_val; 0 = wrap to 0 after tc_val
- count  output  N_CH*WIDTH  registered counts; channel i at bits [i*WIDTH +: WIDTH]
- gnt  output  N_CH  registered one-hot; bit i high for the cycle after channel i was incremented
- done  output  N_CH  registered one-cycle pulse when channel i reaches tc_val
- busy  output  1  registered; high when a grant occurred on the previous edge

Behaviour:
- Reset (reset=0, asynchronous): all counts 0; gnt 0; done 0; busy 0; rr pointer 0; state IDLE.
- States:
  - IDLE: en=1 and some eligible req → RUN.
  - RUN: en=0 → HOLD; no eligible req → IDLE.
  - HOLD: en=1 → RUN if an eligible req exists, else IDLE.
  - State affects gnt/busy only. clr is honoured in every state.
- Eligibility:
  - Channel i is eligible when req[i]=1, clr[i]=0, and NOT (stop_at_tc=1 and count[i]==tc_val).
  - No grant is issued in HOLD or while en=0.
- Arbitration:
  - Combinational, round-robin. Search starts at ptr and proceeds ptr, ptr+1 … mod N_CH.
  - The first eligible channel is sel.
  - On a grant, ptr <= (sel+1) mod N_CH. With no grant, ptr holds.
- Update at the edge where sel is valid:
  - If count[sel]==tc_val: count[sel] <= 0 when stop_at_tc=0 (wrap). The stop_at_tc=1 case cannot occur because the channel is ineligible.
  - Otherwise count[sel] <= count[sel]+1. The WIDTH-bit result wraps at 2^WIDTH−1 → 0 if tc_val is unreachable.
  - gnt <= onehot(sel); busy <= 1.
  - done[sel] <= 1 iff the new count equals tc_val.
- Latency: req sampled in cycle t → new count, gnt and done visible in cycle t+1. Throughput is one increment per cycle total.
- clr[i]=1 → count[i] <= 0 on the next edge, overriding any increment. done[i] stays 0 even if tc_val=0.
- Simultaneous clr on several channels: all clear. The granted channel is any other eligible channel.
- Edges with no grant: gnt=0, busy=0, done=0.
- tc_val changes take effect on the next arbitration. No retro-active done is raised.
- reset asserted mid-operation: immediate clear. The first grant after deassertion goes to the lowest-index eligible channel.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package inc_share_pkg holds:
  - default constants N_CH_DEF=3, WIDTH_DEF=8;
  - state enum {IDLE, RUN, HOLD};
  - function onehot(idx).
- One sub-module, inc_share_adder: WIDTH-bit +1 incrementer, ports a, sum, co. It is combinational and instantiated exactly once, to prove the incrementer is shared.
- Arbiter and writeback logic stay in the top module.

Test Plan:
- Reset then en=1, req=3'b111, tc_val=255, stop_at_tc=0 → grants rotate 001,010,100,001…; after 9 cycles every count=3.
- req=3'b010 only, tc_val=4, stop_at_tc=0 → count1 goes 1,2,3,4(done[1]=1),0,1; channels 0 and 2 stay 0.
- tc_val=2, stop_at_tc=1, req=3'b001 → count0 reaches 2 with done[0] pulsed once; further gnt=0, busy=0, state IDLE.
- Channel 1 mid-count=5 with clr[1]=1 and req=3'b011 in the same cycle → count1=0 and the grant goes to channel 0. The ptr then moves to 1 and the next grant is channel 1.
- en=0 for 3 cycles with req=3'b111 → counts frozen, gnt=0. On en=1, the grant resumes at the saved ptr.
- Assert reset asynchronously between edges while count2=7 → all outputs 0 before the next edge. The first grant after release is channel 0.
